ex_mem_stage: RTL and testbench



---
 rtl/ex_mem_stage.sv | 134 +++++++++++++
 tb/tb_ex_mem_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: RV64 execute stage with EX-hazard forwarding, ALU, branch resolve and EX/MEM register.
module ex_mem_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        Flush,
  input  logic        IDEX_RegWrite,
  input  logic        IDEX_MemToReg,
  input  logic        IDEX_Branch,
  input  logic        IDEX_MemRead,
  input  logic        IDEX_MemWrite,
  input  logic        IDEX_ALUSrc,
  input  logic        IDEX_Shift,
  input  logic [1:0]  IDEX_ALUOp,
  input  logic [63:0] IDEX_PC,
  input  logic [63:0] IDEX_Read_Data_1,
  input  logic [63:0] IDEX_Read_Data_2,
  input  logic [63:0] IDEX_Immediate,
  input  logic [4:0]  IDEX_Rs1,
  input  logic [4:0]  IDEX_Rs2,
  input  logic [4:0]  IDEX_Instruction_11_7,
  input  logic [3:0]  IDEX_Instruction_30_14_12,
  input  logic        MEMWB_RegWrite,
  input  logic [4:0]  MEMWB_Rd,
  input  logic [63:0] MEMWB_Write_Data,
  output logic        EXMEM_RegWrite,
  output logic        EXMEM_MemToReg,
  output logic        EXMEM_MemRead,
  output logic        EXMEM_MemWrite,
  output logic        EXMEM_Branch_Taken,
  output logic [63:0] EXMEM_Branch_Target,
  output logic [63:0] EXMEM_ALU_Result,
  output logic [63:0] EXMEM_Write_Data,
  output logic [4:0]  EXMEM_Rd,
  output logic        EXMEM_Zero
);
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA} alu_op_e;
  logic [3:0] f;
  logic [63:0] fwd_a, fwd_b, op_b, alu_d, target_d;
  logic [5:0] shamt;
  logic taken_d, eq, lt;
  alu_op_e op;
  logic regwrite_q, memtoreg_q, memread_q, memwrite_q, taken_q, zero_q;
  logic [63:0] target_q, alu_q, wdata_q;
  logic [4:0] rd_q;
  assign f = IDEX_Instruction_30_14_12;
  // EX/MEM is the newer producer, so it is checked first
  assign fwd_a = (regwrite_q && rd_q != 5'd0 && rd_q == IDEX_Rs1) ? alu_q :
                 (MEMWB_RegWrite && MEMWB_Rd != 5'd0 && MEMWB_Rd == IDEX_Rs1) ? MEMWB_Write_Data :
                 IDEX_Read_Data_1;
  assign fwd_b = (regwrite_q && rd_q != 5'd0 && rd_q == IDEX_Rs2) ? alu_q :
                 (MEMWB_RegWrite && MEMWB_Rd != 5'd0 && MEMWB_Rd == IDEX_Rs2) ? MEMWB_Write_Data :
                 IDEX_Read_Data_2;
  assign op_b = IDEX_ALUSrc ? IDEX_Immediate : fwd_b;
  assign shamt = op_b[5:0];
  always_comb begin
    op = OP_ADD;
    if (IDEX_ALUOp == 2'b01) op = OP_SUB;
    else if (IDEX_ALUOp == 2'b10)
      case (f)
        4'b1000: op = OP_SUB;
        4'b0111: op = OP_AND;
        4'b0110: op = OP_OR;
        4'b0100: op = OP_XOR;
        4'b0001: op = OP_SLL;
        4'b0101: op = OP_SRL;
        4'b1101: op = OP_SRA;
        default: op = OP_ADD;
      endcase
    else if (IDEX_ALUOp == 2'b11)
      case (f[2:0])
        3'b111:  op = OP_AND;
        3'b110:  op = OP_OR;
        3'b100:  op = OP_XOR;
        3'b001:  op = OP_SLL;
        3'b101:  op = f[3] ? OP_SRA : OP_SRL;
        default: op = OP_ADD;
      endcase
  end
  always_comb begin
    alu_d = fwd_a + op_b;
    case (op)
      OP_SUB:  alu_d = fwd_a - op_b;
      OP_AND:  alu_d = fwd_a & op_b;
      OP_OR:   alu_d = fwd_a | op_b;
      OP_XOR:  alu_d = fwd_a ^ op_b;
      OP_SLL:  alu_d = fwd_a << shamt;
      OP_SRL:  alu_d = fwd_a >> shamt;
      OP_SRA:  alu_d = $signed(fwd_a) >>> shamt;
      default: alu_d = fwd_a + op_b;
    endcase
  end
  assign eq = fwd_a == fwd_b;
  assign lt = $signed(fwd_a) < $signed(fwd_b);
  assign taken_d = IDEX_Branch && (f[2:0] == 3'b000 ? eq :
                                   f[2:0] == 3'b001 ? !eq :
                                   f[2:0] == 3'b100 ? lt :
                                   f[2:0] == 3'b101 ? !lt : 1'b0);
  assign target_d = IDEX_PC + (IDEX_Shift ? IDEX_Immediate << 1 : IDEX_Immediate);
  always_ff @(posedge clock) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= '0;
      alu_q      <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      zero_q     <= 1'b0;
    end else begin
      regwrite_q <= IDEX_RegWrite & ~Flush;
      memtoreg_q <= IDEX_MemToReg & ~Flush;
      memread_q  <= IDEX_MemRead & ~Flush;
      memwrite_q <= IDEX_MemWrite & ~Flush;
      taken_q    <= taken_d & ~Flush;
      target_q   <= target_d;
      alu_q      <= alu_d;
      wdata_q    <= fwd_b;
      rd_q       <= IDEX_Instruction_11_7;
      zero_q     <= alu_d == 64'd0;
    end
  end
  assign EXMEM_RegWrite      = regwrite_q;
  assign EXMEM_MemToReg      = memtoreg_q;
  assign EXMEM_MemRead       = memread_q;
  assign EXMEM_MemWrite      = memwrite_q;
  assign EXMEM_Branch_Taken  = taken_q;
  assign EXMEM_Branch_Target = target_q;
  assign EXMEM_ALU_Result    = alu_q;
  assign EXMEM_Write_Data    = wdata_q;
  assign EXMEM_Rd            = rd_q;
  assign EXMEM_Zero          = zero_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vectors with hand-computed expectations for ex_mem_stage.
module tb_ex_mem_stage;
  logic clock = 1'b0;
  logic reset, Flush;
  logic IDEX_RegWrite, IDEX_MemToReg, IDEX_Branch, IDEX_MemRead, IDEX_MemWrite, IDEX_ALUSrc, IDEX_Shift;
  logic [1:0] IDEX_ALUOp;
  logic [63:0] IDEX_PC, IDEX_Read_Data_1, IDEX_Read_Data_2, IDEX_Immediate;
  logic [4:0] IDEX_Rs1, IDEX_Rs2, IDEX_Instruction_11_7;
  logic [3:0] IDEX_Instruction_30_14_12;
  logic MEMWB_RegWrite;
  logic [4:0] MEMWB_Rd;
  logic [63:0] MEMWB_Write_Data;
  logic EXMEM_RegWrite, EXMEM_MemToReg, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_Branch_Taken, EXMEM_Zero;
  logic [63:0] EXMEM_Branch_Target, EXMEM_ALU_Result, EXMEM_Write_Data;
  logic [4:0] EXMEM_Rd;
  int n_vec = 0;
  int n_err = 0;

  ex_mem_stage dut (
    .clock(clock), .reset(reset), .Flush(Flush),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemToReg(IDEX_MemToReg), .IDEX_Branch(IDEX_Branch),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite), .IDEX_ALUSrc(IDEX_ALUSrc),
    .IDEX_Shift(IDEX_Shift), .IDEX_ALUOp(IDEX_ALUOp), .IDEX_PC(IDEX_PC),
    .IDEX_Read_Data_1(IDEX_Read_Data_1), .IDEX_Read_Data_2(IDEX_Read_Data_2),
    .IDEX_Immediate(IDEX_Immediate), .IDEX_Rs1(IDEX_Rs1), .IDEX_Rs2(IDEX_Rs2),
    .IDEX_Instruction_11_7(IDEX_Instruction_11_7),
    .IDEX_Instruction_30_14_12(IDEX_Instruction_30_14_12),
    .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_Rd(MEMWB_Rd), .MEMWB_Write_Data(MEMWB_Write_Data),
    .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_MemToReg(EXMEM_MemToReg),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .EXMEM_Branch_Taken(EXMEM_Branch_Taken), .EXMEM_Branch_Target(EXMEM_Branch_Target),
    .EXMEM_ALU_Result(EXMEM_ALU_Result), .EXMEM_Write_Data(EXMEM_Write_Data),
    .EXMEM_Rd(EXMEM_Rd), .EXMEM_Zero(EXMEM_Zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 0; Flush = 0;
    IDEX_RegWrite = 0; IDEX_MemToReg = 0; IDEX_Branch = 0; IDEX_MemRead = 0;
    IDEX_MemWrite = 0; IDEX_ALUSrc = 0; IDEX_Shift = 0; IDEX_ALUOp = 2'b00;
    IDEX_PC = 0; IDEX_Read_Data_1 = 0; IDEX_Read_Data_2 = 0; IDEX_Immediate = 0;
    IDEX_Rs1 = 0; IDEX_Rs2 = 0; IDEX_Instruction_11_7 = 0; IDEX_Instruction_30_14_12 = 0;
    MEMWB_RegWrite = 0; MEMWB_Rd = 0; MEMWB_Write_Data = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic alu(input logic [1:0] aop, input logic [3:0] fn, input logic [63:0] a,
                     input logic [63:0] b, input logic src, input string tag, input logic [63:0] exp);
    idle();
    IDEX_ALUOp = aop; IDEX_Instruction_30_14_12 = fn; IDEX_Read_Data_1 = a;
    IDEX_ALUSrc = src;
    if (src) IDEX_Immediate = b; else IDEX_Read_Data_2 = b;
    step();
    chk(tag, EXMEM_ALU_Result, exp);
  endtask

  initial begin
    idle();
    // reset with every input nonzero, Flush included
    reset = 1; Flush = 1;
    {IDEX_RegWrite, IDEX_MemToReg, IDEX_Branch, IDEX_MemRead, IDEX_MemWrite, IDEX_ALUSrc, IDEX_Shift} = '1;
    IDEX_ALUOp = 2'b10; IDEX_PC = 64'h100; IDEX_Read_Data_1 = 64'h5; IDEX_Read_Data_2 = 64'h5;
    IDEX_Immediate = 64'h9; IDEX_Rs1 = 1; IDEX_Rs2 = 2; IDEX_Instruction_11_7 = 3;
    IDEX_Instruction_30_14_12 = 4'b0001; MEMWB_RegWrite = 1; MEMWB_Rd = 4; MEMWB_Write_Data = 64'h77;
    step();
    chk("rst_ctrl", {59'd0, EXMEM_RegWrite, EXMEM_MemToReg, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_Branch_Taken}, 0);
    chk("rst_target", EXMEM_Branch_Target, 0);
    chk("rst_alu", EXMEM_ALU_Result, 0);
    chk("rst_wdata", EXMEM_Write_Data, 0);
    chk("rst_rd_zero", {58'd0, EXMEM_Rd, EXMEM_Zero}, 0);

    // add x5 = 7 + 3
    idle();
    IDEX_ALUOp = 2'b10; IDEX_RegWrite = 1; IDEX_Rs1 = 1; IDEX_Rs2 = 2;
    IDEX_Read_Data_1 = 7; IDEX_Read_Data_2 = 3; IDEX_Instruction_11_7 = 5;
    step();
    chk("add_res", EXMEM_ALU_Result, 10);
    chk("add_rd", EXMEM_Rd, 5);
    chk("add_regwrite", EXMEM_RegWrite, 1);
    chk("add_wdata", EXMEM_Write_Data, 3);

    // sub x6 = x5 - 4 with stale rs1 data
    idle();
    IDEX_ALUOp = 2'b10; IDEX_Instruction_30_14_12 = 4'b1000; IDEX_RegWrite = 1;
    IDEX_Rs1 = 5; IDEX_Rs2 = 7; IDEX_Read_Data_2 = 4; IDEX_Instruction_11_7 = 6;
    step();
    chk("sub_fwd_exmem", EXMEM_ALU_Result, 6);

    // produce x5 = 100 in EX/MEM
    idle();
    IDEX_RegWrite = 1; IDEX_Rs1 = 1; IDEX_Read_Data_1 = 100; IDEX_Instruction_11_7 = 5;
    step();
    chk("x5_100", EXMEM_ALU_Result, 100);
    // double hazard: EX/MEM x5=100 beats MEM/WB x5=200
    idle();
    IDEX_Rs1 = 5; MEMWB_RegWrite = 1; MEMWB_Rd = 5; MEMWB_Write_Data = 200;
    step();
    chk("double_hazard", EXMEM_ALU_Result, 100);

    // MEM/WB forwarding alone on rs2 (store data)
    idle();
    IDEX_MemWrite = 1; IDEX_Rs2 = 9; IDEX_Read_Data_2 = 1;
    MEMWB_RegWrite = 1; MEMWB_Rd = 9; MEMWB_Write_Data = 55;
    step();
    chk("memwb_fwd_b", EXMEM_Write_Data, 55);

    // x0 guard on rs2
    idle();
    IDEX_MemWrite = 1; IDEX_ALUSrc = 1; IDEX_Read_Data_1 = 64'h40; IDEX_Immediate = 8;
    MEMWB_RegWrite = 1; MEMWB_Rd = 0; MEMWB_Write_Data = 64'hDEAD;
    step();
    chk("x0_wdata", EXMEM_Write_Data, 0);
    chk("x0_addr", EXMEM_ALU_Result, 64'h48);
    chk("x0_memwrite", EXMEM_MemWrite, 1);

    // blt -1 < 1, target = 0x100 + (0x20<<1)
    idle();
    IDEX_Branch = 1; IDEX_ALUOp = 2'b01; IDEX_Instruction_30_14_12 = 4'b0100;
    IDEX_Rs1 = 1; IDEX_Rs2 = 2; IDEX_Read_Data_1 = '1; IDEX_Read_Data_2 = 1;
    IDEX_PC = 64'h100; IDEX_Immediate = 64'h20; IDEX_Shift = 1;
    step();
    chk("blt_taken", EXMEM_Branch_Taken, 1);
    chk("blt_target", EXMEM_Branch_Target, 64'h140);
    chk("blt_sub", EXMEM_ALU_Result, 64'hFFFF_FFFF_FFFF_FFFE);
    IDEX_Instruction_30_14_12 = 4'b0101;
    step();
    chk("bge_taken", EXMEM_Branch_Taken, 0);
    // beq equal, no target shift
    IDEX_Instruction_30_14_12 = 4'b0000; IDEX_Read_Data_1 = 5; IDEX_Read_Data_2 = 5; IDEX_Shift = 0;
    step();
    chk("beq_taken", EXMEM_Branch_Taken, 1);
    chk("beq_zero", EXMEM_Zero, 1);
    chk("beq_target", EXMEM_Branch_Target, 64'h120);
    // bne on equal operands, and equal-compare with Branch=0
    IDEX_Instruction_30_14_12 = 4'b0001;
    step();
    chk("bne_taken", EXMEM_Branch_Taken, 0);
    IDEX_Instruction_30_14_12 = 4'b0000; IDEX_Branch = 0;
    step();
    chk("nobranch_taken", EXMEM_Branch_Taken, 0);

    // flushed store that also claims RegWrite to x3
    idle();
    Flush = 1; IDEX_MemWrite = 1; IDEX_RegWrite = 1; IDEX_MemRead = 1; IDEX_MemToReg = 1;
    IDEX_Read_Data_1 = 64'h999; IDEX_Instruction_11_7 = 3;
    step();
    chk("flush_memwrite", EXMEM_MemWrite, 0);
    chk("flush_regwrite", EXMEM_RegWrite, 0);
    chk("flush_memread", {EXMEM_MemRead, EXMEM_MemToReg}, 0);
    // the bubble must not forward
    idle();
    IDEX_Rs1 = 3; IDEX_Read_Data_1 = 11;
    step();
    chk("bubble_nofwd", EXMEM_ALU_Result, 11);

    // shifts and logic ops
    alu(2'b11, 4'b1101, 64'h8000_0000_0000_0000, 4, 1'b1, "srai", 64'hF800_0000_0000_0000);
    alu(2'b11, 4'b0101, 64'h8000_0000_0000_0000, 4, 1'b1, "srli", 64'h0800_0000_0000_0000);
    alu(2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'h43, 1'b0, "sra_shamt6", 64'hF000_0000_0000_0000);
    alu(2'b10, 4'b0001, 1, 64'h44, 1'b0, "sll", 64'h10);
    alu(2'b10, 4'b0111, 64'hF0, 64'h3C, 1'b0, "and", 64'h30);
    alu(2'b10, 4'b0110, 64'hF0, 64'h3C, 1'b0, "or", 64'hFC);
    alu(2'b10, 4'b0100, 64'hF0, 64'h3C, 1'b0, "xor", 64'hCC);
    alu(2'b10, 4'b0010, 64'hF0, 64'h3C, 1'b0, "rtype_default", 64'h12C);
    alu(2'b11, 4'b1111, 64'hF0, 64'h3C, 1'b1, "andi_f3_ignored", 64'h30);
    alu(2'b11, 4'b1000, 64'h5, 64'h3, 1'b1, "addi_f3_ignored", 64'h8);
    alu(2'b00, 4'b1000, '1, 1, 1'b1, "add_wrap", 0);
    chk("wrap_zero", EXMEM_Zero, 1);
    alu(2'b01, 4'b0000, 0, 1, 1'b0, "sub_wrap", '1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
